// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding, header width
// and default geometry.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR0  = 3'd1,
    ST_HDR1  = 3'd2,
    ST_DATA  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } state_t;

  localparam int HDR_WIDTH          = 16;
  localparam int DEFAULT_ADDR_WIDTH = 8;
  localparam int DEFAULT_MAX_WORDS  = 256;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write bus of the program loader.
// Handshake: a byte moves on a rising edge where byte_valid && byte_ready are
// both high; the source holds byte_data stable while byte_valid is high and
// byte_ready never depends combinationally on byte_valid.
interface program_loader_if #(
  parameter int ADDR_WIDTH = 8
) ();
  logic                  byte_valid;
  logic [7:0]            byte_data;
  logic                  byte_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/program_loader_word_assembler.sv
// Collects four bytes, least-significant first, into one 32-bit word.
// word_full flags the cycle in which the fourth byte is being accepted.
module word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_full
);

  logic [1:0]  lane_q;
  logic [31:0] word_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_q <= 2'd0;
      word_q <= 32'd0;
    end else if (clear) begin
      lane_q <= 2'd0;
      word_q <= 32'd0;
    end else if (byte_en) begin
      word_q[{lane_q, 3'b000} +: 8] <= byte_data;
      lane_q                        <= lane_q + 2'd1;
    end
  end

  assign word      = word_q;
  assign word_full = byte_en && (lane_q == 2'd3);

endmodule

// File: rtl/program_loader.sv
// Boot loader: parses a length-prefixed byte stream, writes the words to
// instruction memory from address 0 and holds the core in reset until done.
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int MAX_WORDS  = DEFAULT_MAX_WORDS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  program_loader_if.slave   bus,
  output logic              core_reset,
  output logic              done,
  output logic              error,
  output logic [ADDR_WIDTH:0] words_loaded,
  output state_t            dbg_state
);

  state_t                 state_q, state_d;
  logic [HDR_WIDTH-1:0]   count_q, count_d, hdr_len;
  logic [ADDR_WIDTH:0]    wl_q, wl_d, wl_inc;
  logic [ADDR_WIDTH-1:0]  mem_addr_q;
  logic                   byte_ready_q, mem_we_q, core_reset_q, done_q, error_q;
  logic                   accept, byte_en, asm_clear, word_full, hdr_ok;
  logic [31:0]            asm_word;

  assign accept  = bus.byte_valid && byte_ready_q;
  assign byte_en = accept && (state_q == ST_DATA);
  assign hdr_len = {bus.byte_data, count_q[7:0]};
  assign hdr_ok  = (hdr_len != '0) && (32'(hdr_len) <= MAX_WORDS);
  assign wl_inc  = wl_q + (ADDR_WIDTH+1)'(1);

  word_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (asm_clear),
    .byte_en   (byte_en),
    .byte_data (bus.byte_data),
    .word      (asm_word),
    .word_full (word_full)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    wl_d      = wl_q;
    asm_clear = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d   = ST_HDR0;
        wl_d      = '0;
        asm_clear = 1'b1;
      end
      ST_HDR0: if (accept) begin
        count_d[7:0] = bus.byte_data;
        state_d      = ST_HDR1;
      end
      ST_HDR1: if (accept) begin
        count_d[15:8] = bus.byte_data;
        state_d       = hdr_ok ? ST_DATA : ST_ERR;
      end
      ST_DATA: if (word_full) state_d = ST_WRITE;
      ST_WRITE: begin
        wl_d      = wl_inc;
        asm_clear = 1'b1;
        state_d   = (HDR_WIDTH'(wl_inc) == count_q) ? ST_DONE : ST_DATA;
      end
      ST_DONE, ST_ERR: if (start) begin
        state_d   = ST_HDR0;
        wl_d      = '0;
        asm_clear = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      wl_q         <= '0;
      mem_addr_q   <= '0;
      byte_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      wl_q         <= wl_d;
      byte_ready_q <= (state_d == ST_HDR0) || (state_d == ST_HDR1) || (state_d == ST_DATA);
      mem_we_q     <= (state_d == ST_WRITE);
      core_reset_q <= (state_d != ST_DONE);
      done_q       <= (state_d == ST_DONE);
      error_q      <= (state_d == ST_ERR);
      if (state_d == ST_WRITE) mem_addr_q <= wl_q[ADDR_WIDTH-1:0];
    end
  end

  assign bus.byte_ready = byte_ready_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = asm_word;
  assign core_reset     = core_reset_q;
  assign done           = done_q;
  assign error          = error_q;
  assign words_loaded   = wl_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: one task per scenario, write log
// checked against an expected queue of {addr, data} entries.
module tb_program_loader;
  import loader_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        core_reset, done, error;
  logic [8:0]  words_loaded;
  state_t      dbg_state;

  int          chk_cnt = 0;
  int          pass_cnt = 0;
  logic [39:0] exp_q[$];
  logic [39:0] got_q[$];
  logic [31:0] img [0:7];
  logic        in_load = 1'b0;
  int          ready_gaps = 0;

  program_loader_if #(.ADDR_WIDTH(8)) bus ();

  program_loader #(.ADDR_WIDTH(8), .MAX_WORDS(256)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .bus          (bus),
    .core_reset   (core_reset),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded),
    .dbg_state    (dbg_state)
  );

  always #5 clk = ~clk;

  // Write monitor and byte_ready gap counter, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.mem_we) got_q.push_back({bus.mem_addr, bus.mem_wdata});
    if (in_load && !bus.byte_ready && !bus.mem_we && !done && !error) ready_gaps++;
  end

  function automatic int write_errs(input int base);
    int n;
    n = 0;
    if (got_q.size() - base != exp_q.size()) n++;
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i >= got_q.size() || got_q[base + i] !== exp_q[i]) n++;
    return n;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) begin @(posedge clk); #1; end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    n = 0;
    @(negedge clk);
    while (!bus.byte_ready && n < 40) begin n++; @(negedge clk); end
    if (!bus.byte_ready) begin
      chk_cnt++;
      $display("FAIL byte_accept_timeout: byte %h byte_ready=%b required 1", b, bus.byte_ready);
    end
    @(posedge clk); #1;
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_image(input logic [15:0] hdr, input int nw, input int gap);
    send_byte(hdr[7:0], gap);
    send_byte(hdr[15:8], gap);
    for (int w = 0; w < nw; w++) begin
      exp_q.push_back({8'(w), img[w]});
      for (int k = 0; k < 4; k++) send_byte(img[w][8*k +: 8], gap);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_cnt++;
    if ({bus.byte_ready, bus.mem_we, core_reset, done, error} !== 5'b00100)
      $display("FAIL reset_ctrl: got %b required 00100", {bus.byte_ready, bus.mem_we, core_reset, done, error});
    else pass_cnt++;
    chk_cnt++;
    if (bus.mem_addr !== 8'd0) $display("FAIL reset_addr: got %h required 00", bus.mem_addr);
    else pass_cnt++;
    chk_cnt++;
    if (bus.mem_wdata !== 32'd0) $display("FAIL reset_wdata: got %h required 0", bus.mem_wdata);
    else pass_cnt++;
    chk_cnt++;
    if (words_loaded !== 9'd0) $display("FAIL reset_count: got %0d required 0", words_loaded);
    else pass_cnt++;
    reset = 1'b0;
  endtask

  task automatic test_nominal();
    int base;
    base = got_q.size();
    exp_q.delete();
    img[0] = 32'h002081B3; img[1] = 32'h40208233; img[2] = 32'h00418463;
    pulse_start();
    chk_cnt++;
    if (bus.byte_ready !== 1'b1) $display("FAIL nominal_ready_after_start: got %b required 1", bus.byte_ready);
    else pass_cnt++;
    send_image(16'd3, 3, 0);
    chk_cnt++;
    if ({bus.mem_we, bus.mem_addr, bus.mem_wdata, done, core_reset} !== {1'b1, 8'd2, 32'h00418463, 1'b0, 1'b1})
      $display("FAIL nominal_last_write: got we=%b addr=%h data=%h done=%b core_reset=%b required 1/02/00418463/0/1",
               bus.mem_we, bus.mem_addr, bus.mem_wdata, done, core_reset);
    else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++;
    if ({done, core_reset, bus.mem_we, bus.byte_ready} !== 4'b1000)
      $display("FAIL nominal_release: got done/core_reset/we/ready=%b required 1000", {done, core_reset, bus.mem_we, bus.byte_ready});
    else pass_cnt++;
    chk_cnt++;
    if (words_loaded !== 9'd3) $display("FAIL nominal_count: got %0d required 3", words_loaded);
    else pass_cnt++;
    chk_cnt++;
    if (write_errs(base) !== 0) $display("FAIL nominal_writes: %0d bad writes required 0", write_errs(base));
    else pass_cnt++;
    // Extra bytes after the image must never be taken.
    bus.byte_valid = 1'b1; bus.byte_data = 8'hAA;
    repeat (5) @(posedge clk);
    #1;
    bus.byte_valid = 1'b0;
    chk_cnt++;
    if ({bus.byte_ready, words_loaded, done} !== {1'b0, 9'd3, 1'b1} || got_q.size() - base !== 3)
      $display("FAIL nominal_extra_bytes: ready=%b count=%0d done=%b writes=%0d required 0/3/1/3",
               bus.byte_ready, words_loaded, done, got_q.size() - base);
    else pass_cnt++;
  endtask

  task automatic test_stalls();
    int base, gaps0;
    base = got_q.size();
    exp_q.delete();
    pulse_start();
    in_load = 1'b1;
    gaps0 = ready_gaps;
    send_image(16'd3, 3, 3);
    @(posedge clk); #1;
    in_load = 1'b0;
    chk_cnt++;
    if (write_errs(base) !== 0) $display("FAIL stall_writes: %0d bad writes required 0", write_errs(base));
    else pass_cnt++;
    chk_cnt++;
    if (ready_gaps - gaps0 !== 0) $display("FAIL stall_ready_drop: %0d cycles required 0", ready_gaps - gaps0);
    else pass_cnt++;
    chk_cnt++;
    if ({done, core_reset, words_loaded} !== {1'b1, 1'b0, 9'd3})
      $display("FAIL stall_done: done=%b core_reset=%b count=%0d required 1/0/3", done, core_reset, words_loaded);
    else pass_cnt++;
  endtask

  task automatic test_bad_header();
    int base;
    base = got_q.size();
    exp_q.delete();
    pulse_start();
    send_image(16'd0, 0, 0);
    chk_cnt++;
    if ({error, core_reset, done, bus.byte_ready} !== 4'b1100)
      $display("FAIL bad_zero: error/core_reset/done/ready=%b required 1100", {error, core_reset, done, bus.byte_ready});
    else pass_cnt++;
    pulse_start();
    chk_cnt++;
    if ({error, core_reset, bus.byte_ready} !== 3'b011)
      $display("FAIL bad_restart: error/core_reset/ready=%b required 011", {error, core_reset, bus.byte_ready});
    else pass_cnt++;
    send_image(16'd257, 0, 0);
    chk_cnt++;
    if ({error, core_reset, done} !== 3'b110)
      $display("FAIL bad_over_max: error/core_reset/done=%b required 110", {error, core_reset, done});
    else pass_cnt++;
    chk_cnt++;
    if (got_q.size() - base !== 0) $display("FAIL bad_no_write: %0d writes required 0", got_q.size() - base);
    else pass_cnt++;
    img[0] = 32'hDEADBEEF;
    pulse_start();
    send_image(16'd1, 1, 0);
    @(posedge clk); #1;
    chk_cnt++;
    if ({error, done, core_reset, words_loaded} !== {1'b0, 1'b1, 1'b0, 9'd1})
      $display("FAIL bad_recover: error=%b done=%b core_reset=%b count=%0d required 0/1/0/1",
               error, done, core_reset, words_loaded);
    else pass_cnt++;
    chk_cnt++;
    if (write_errs(base) !== 0) $display("FAIL bad_recover_writes: %0d bad writes required 0", write_errs(base));
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int base;
    base = got_q.size();
    exp_q.delete();
    img[0] = 32'h11223344; img[1] = 32'h55667788;
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    chk_cnt++;
    if ({error, bus.byte_ready, dbg_state} !== {1'b0, 1'b1, ST_DATA})
      $display("FAIL max_len_accept: error=%b ready=%b state=%0d required 0/1/%0d", error, bus.byte_ready, dbg_state, ST_DATA);
    else pass_cnt++;
    exp_q.push_back({8'd0, img[0]});
    for (int k = 0; k < 4; k++) send_byte(img[0][8*k +: 8], 0);
    send_byte(img[1][7:0], 0);
    send_byte(img[1][15:8], 0);
    #2 reset = 1'b1;
    #1;
    chk_cnt++;
    if ({bus.byte_ready, bus.mem_we, core_reset, done, error, words_loaded, bus.mem_wdata} !==
        {5'b00100, 9'd0, 32'd0})
      $display("FAIL reset_mid_async: ctrl=%b count=%0d wdata=%h required 00100/0/0",
               {bus.byte_ready, bus.mem_we, core_reset, done, error}, words_loaded, bus.mem_wdata);
    else pass_cnt++;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_cnt++;
    if (write_errs(base) !== 0) $display("FAIL reset_mid_writes: %0d bad writes required 0", write_errs(base));
    else pass_cnt++;
    base = got_q.size();
    exp_q.delete();
    img[0] = 32'hCAFEF00D;
    pulse_start();
    send_image(16'd1, 1, 0);
    @(posedge clk); #1;
    chk_cnt++;
    if (write_errs(base) !== 0 || done !== 1'b1)
      $display("FAIL reset_mid_reload: %0d bad writes done=%b required 0/1", write_errs(base), done);
    else pass_cnt++;
  endtask

  task automatic test_reload_ignored_start();
    int base;
    base = got_q.size();
    exp_q.delete();
    img[0] = 32'h0A0B0C0D; img[1] = 32'h80706050;
    pulse_start();
    chk_cnt++;
    if ({core_reset, done, words_loaded, bus.byte_ready} !== {1'b1, 1'b0, 9'd0, 1'b1})
      $display("FAIL reload_start: core_reset=%b done=%b count=%0d ready=%b required 1/0/0/1",
               core_reset, done, words_loaded, bus.byte_ready);
    else pass_cnt++;
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    for (int k = 0; k < 4; k++) send_byte(img[0][8*k +: 8], 0);
    send_byte(img[1][7:0], 1);
    pulse_start();
    chk_cnt++;
    if ({words_loaded, bus.byte_ready, dbg_state} !== {9'd1, 1'b1, ST_DATA})
      $display("FAIL ignored_start: count=%0d ready=%b state=%0d required 1/1/%0d", words_loaded, bus.byte_ready, dbg_state, ST_DATA);
    else pass_cnt++;
    for (int k = 1; k < 4; k++) send_byte(img[1][8*k +: 8], 0);
    exp_q.push_back({8'd0, img[0]});
    exp_q.push_back({8'd1, img[1]});
    @(posedge clk); #1;
    chk_cnt++;
    if (write_errs(base) !== 0) $display("FAIL reload_writes: %0d bad writes required 0", write_errs(base));
    else pass_cnt++;
    chk_cnt++;
    if ({done, core_reset, words_loaded} !== {1'b1, 1'b0, 9'd2})
      $display("FAIL reload_done: done=%b core_reset=%b count=%0d required 1/0/2", done, core_reset, words_loaded);
    else pass_cnt++;
  endtask

  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    test_reset();
    test_nominal();
    test_stalls();
    test_bad_header();
    test_reset_mid();
    test_reload_ignored_start();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
